// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and the load/store unit state encoding.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality check, load extract/extend, store merge.
module lsu_align
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            chk_store,
  input  logic [2:0]      chk_funct3,
  input  logic [1:0]      chk_off,
  output logic            chk_err,
  input  logic [2:0]      lane_funct3,
  input  logic [1:0]      lane_off,
  input  logic [XLEN-1:0] mem_word,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] ld_result,
  output logic [XLEN-1:0] merged
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = mem_word[{lane_off, 3'b000} +: 8];
  assign ld_half = mem_word[{lane_off[1], 4'b0000} +: 16];

  always_comb begin
    chk_err = 1'b0;
    if (chk_store) begin
      case (chk_funct3)
        F3_B:    chk_err = 1'b0;
        F3_H:    chk_err = chk_off[0];
        F3_W:    chk_err = (chk_off != 2'b00);
        default: chk_err = 1'b1;
      endcase
    end else begin
      case (chk_funct3)
        F3_B, F3_BU: chk_err = 1'b0;
        F3_H, F3_HU: chk_err = chk_off[0];
        F3_W:        chk_err = (chk_off != 2'b00);
        default:     chk_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    ld_result = mem_word;
    case (lane_funct3)
      F3_B:    ld_result = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_result = {{(XLEN-8){1'b0}}, ld_byte};
      F3_H:    ld_result = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_result = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_result = mem_word;
    endcase
  end

  always_comb begin
    merged = mem_word;
    case (lane_funct3)
      F3_B:    merged[{lane_off, 3'b000} +: 8] = st_data[7:0];
      F3_H:    merged[{lane_off[1], 4'b0000} +: 16] = st_data[15:0];
      default: merged = st_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, word-wide data_mem accesses,
// read-modify-write for sub-word stores.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_op,
  output logic              mem_wr,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              mem_op_q, mem_op_d;
  logic              mem_wr_q, mem_wr_d;

  logic              store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [XLEN-1:0]   wdata_q;

  logic              accept;
  logic              chk_err;
  logic [XLEN-1:0]   ld_result;
  logic [XLEN-1:0]   merged;
  logic              unused_addr_hi;

  // Upper address bits alias onto the data_mem window.
  assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_W];

  assign accept = req_valid && req_ready_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .chk_store   (req_store),
    .chk_funct3  (req_funct3),
    .chk_off     (req_addr[1:0]),
    .chk_err     (chk_err),
    .lane_funct3 (funct3_q),
    .lane_off    (off_q),
    .mem_word    (mem_rdata),
    .st_data     (wdata_q),
    .ld_result   (ld_result),
    .merged      (merged)
  );

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_op_d    = 1'b0;
    mem_wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
          if (chk_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_store && (req_funct3 == F3_W)) begin
            state_d     = WR;
            mem_op_d    = 1'b1;
            mem_wr_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d  = RD;
            mem_op_d = 1'b1;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        // mem_rdata carries the word read during RD.
        if (store_q) begin
          state_d     = WR;
          mem_op_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = ld_result;
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_op_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_op_q    <= mem_op_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  // Request fields are only consumed after an accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      store_q  <= req_store;
      funct3_q <= req_funct3;
      off_q    <= req_addr[1:0];
      wdata_q  <= req_wdata;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_op    = mem_op_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and data_mem. Accepts one RV32I load or store request at a time.
- Converts each request into word-wide data_mem accesses. Sub-word stores use read-modify-write.
- Extracts load results with sign or zero extension, and rejects misaligned or illegal accesses without touching memory.

Parameters:
- ADDR_W, 12, byte-address width presented to data_mem.
- XLEN, 32, data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted when req_valid and req_ready are both 1 at a clk edge.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW encodings).
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse: transaction complete.
- rsp_rdata  out  XLEN  load result. 0 for stores and errors.
- rsp_err  out  1  misaligned address or illegal funct3. Valid with rsp_valid.
- mem_addr  out  ADDR_W  to data_mem Addr. Always word-aligned: {req_addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  XLEN  to data_mem DataIn.
- mem_op  out  1  to data_mem MemOp (access enable).
- mem_wr  out  1  to data_mem MemWr (write enable).
- mem_rdata  in  XLEN  from data_mem DataOut. Valid the cycle after a read is presented.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_op=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Accept: on an accepting edge, latch store, funct3, addr and wdata. req_ready=0 in every state except IDLE.
- Address handling: req_addr[XLEN-1:ADDR_W] is ignored; upper addresses alias with no error.
- Error check at accept:
  - LH/LHU/SH with addr[0]=1 is an error.
  - LW/SW with addr[1:0]!=0 is an error.
  - Illegal funct3 is an error: loads 011/110/111, stores 011 or above.
  - On error, go to RESP with rsp_err=1. No mem_op is issued.
- States and memory signals (mem signals are driven from state and latched registers only):
  - IDLE: no memory access.
  - RD: mem_op=1, mem_wr=0.
  - CAP: mem_rdata is sampled at the end of this cycle.
  - WR: mem_op=1, mem_wr=1.
  - RESP: rsp_valid=1 for exactly one cycle, then return to IDLE.
- Transitions:
  - Load: IDLE -> RD -> CAP -> RESP. rsp_valid is high in the 3rd cycle after the accept edge.
  - SW: IDLE -> WR -> RESP. mem_wdata = wdata.
  - SB/SH: IDLE -> RD -> CAP -> WR -> RESP. In WR, mem_wdata = the word captured in CAP with the addressed byte or half replaced. Byte lane = addr[1:0]; half lane = addr[1].
  - Error: IDLE -> RESP.
- Load extract: select byte lane addr[1:0] or half lane addr[1].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- rsp_rdata holds its value until the next RESP. It is 0 for stores and errors.
- No response backpressure. A new request can be accepted in the cycle after RESP, since IDLE re-asserts req_ready.
- Reset mid-transaction: the transaction is aborted and no response is produced. mem_wr drops immediately, asynchronously. A partial RMW never writes.
- Inputs are ignored while req_ready=0.

Decomposition:
- rv32i_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state encoding: IDLE, RD, CAP, WR, RESP.
- One combinational sub-module, lsu_align, provides:
  - a misalign/illegal check;
  - load lane extract and extension;
  - store lane merge.
- The FSM and registers stay in load_store_unit.

Test Plan:
1. SW 0xDEADBEEF @0x000, then LW @0x000 -> single mem_wr pulse with mem_addr=0x000 and mem_wdata=0xDEADBEEF; the load returns rsp_rdata=0xDEADBEEF, rsp_err=0, 3 cycles after accept.
2. SW 0x12345678 @0x004, then SB wdata=0x000000AA @0x007 -> RD then WR at mem_addr=0x004 with mem_wdata=0xAA345678. Follow-up:
   - LW @0x004 -> 0xAA345678.
   - LB @0x007 -> 0xFFFFFFAA.
   - LBU @0x007 -> 0x000000AA.
3. SH wdata=0x0000BEEF @0x002 over word 0xDEADBEEF @0x000 -> memory word 0xBEEFBEEF. Follow-up:
   - LH @0x002 -> 0xFFFFBEEF.
   - LHU @0x000 -> 0x0000BEEF.
4. Error cases, each giving rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after accept, and mem_op never 1:
   - LW @0x002.
   - SH @0x005.
   - Load funct3=011.
5. Back-to-back: hold req_valid high through 3 loads -> req_ready pulses only in IDLE; the 3 responses arrive in order with no lost or duplicate rsp_valid.
6. Assert rst=0 during the RD state of an SB -> mem_op and mem_wr drop immediately, no write occurs, no rsp_valid is produced; after release, LW of the target word returns its original value.
